// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Bridges the MEM pipeline stage to a data cache. A load or store present in
//   EX/MEM is latched into the cache_* request registers. A one-cycle request
//   strobe is issued, and then the controller waits for a hit response. While a
//   request is outstanding, the upstream pipeline is frozen through mem_stall.
//   A watchdog bounds the wait. When it expires, timeout_err is set and stays
//   set until reset.
//
//   Handshake: a request is taken from EX/MEM only in IDLE when op is high and
//   cache_is_ready is high. cache_is_input_valid then pulses for exactly one
//   cycle. The cache completes the request by raising cache_is_output_valid
//   together with cache_is_hit in a WAIT cycle. mem_dout_valid pulses for one
//   cycle in DONE, and only for loads.
//
//   Optional feature: define MEM_STAT_EN to add the hit_count/miss_count ports
//   and counters.
//
// Parameters
//   TIMEOUT_CYCLES  max WAIT cycles before timeout_err (1..255)
// Ports
//   clk, reset                        clock, async active-high reset
//   ex_mem_valid/mem_read/mem_write   MEM-stage instruction and access type
//   ex_mem_addr, ex_mem_din           byte address, store data
//   cache_is_input_valid              one-cycle request strobe to cache
//   cache_mem_read/cache_mem_write    latched access type
//   cache_addr, cache_din             latched address / store data
//   cache_is_ready                    cache can accept a request
//   cache_is_output_valid, cache_is_hit, cache_dout   cache response
//   mem_stall                         freeze IF..EX/MEM registers
//   mem_dout, mem_dout_valid          load result, valid one cycle
//   timeout_err                       sticky watchdog error
//   hit_count, miss_count             (MEM_STAT_EN) response statistics
//   fsm_state                         debug view of the controller state
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_din,
  output logic        cache_is_input_valid,
  output logic        cache_mem_read,
  output logic        cache_mem_write,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_din,
  input  logic        cache_is_ready,
  input  logic        cache_is_output_valid,
  input  logic        cache_is_hit,
  input  logic [31:0] cache_dout,
  output logic        mem_stall,
  output logic [31:0] mem_dout,
  output logic        mem_dout_valid,
  output logic        timeout_err,
`ifdef MEM_STAT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // wait_cnt holds the number of WAIT cycles already completed. The final
  // allowed cycle is therefore the one that starts with the count at limit-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       op;
  logic       resp;

  assign op        = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
  assign resp      = cache_is_output_valid & cache_is_hit;
  assign mem_stall = ((state == IDLE) & op) | (state == REQ) | (state == WAIT);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      wait_cnt             <= 8'd0;
      cache_is_input_valid <= 1'b0;
      cache_mem_read       <= 1'b0;
      cache_mem_write      <= 1'b0;
      cache_addr           <= 32'd0;
      cache_din            <= 32'd0;
      mem_dout             <= 32'd0;
      mem_dout_valid       <= 1'b0;
      timeout_err          <= 1'b0;
`ifdef MEM_STAT_EN
      hit_count            <= 32'd0;
      miss_count           <= 32'd0;
`endif
    end else begin
      // Both pulse outputs default low. They are raised only on the
      // transition into the state that owns them.
      cache_is_input_valid <= 1'b0;
      mem_dout_valid       <= 1'b0;
      case (state)
        IDLE: begin
          if (op && cache_is_ready) begin
            cache_addr           <= ex_mem_addr;
            cache_din            <= ex_mem_din;
            // Read and write together is illegal. That case is served as a read.
            cache_mem_read       <= ex_mem_mem_read;
            cache_mem_write      <= ex_mem_mem_write & ~ex_mem_mem_read;
            cache_is_input_valid <= 1'b1;
            state                <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (resp) begin
            if (cache_mem_read) begin
              mem_dout       <= cache_dout;
              mem_dout_valid <= 1'b1;
            end
`ifdef MEM_STAT_EN
            // A hit is a response in the first WAIT cycle. Any later response
            // is counted as a miss.
            if (wait_cnt == 8'd0) hit_count  <= hit_count + 32'd1;
            else                  miss_count <= miss_count + 32'd1;
`endif
            state <= DONE;
          end else if (wait_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TMO = 10;

  logic        clk;
  logic        reset;
  logic        ex_mem_valid;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_din;
  logic        cache_is_input_valid;
  logic        cache_mem_read;
  logic        cache_mem_write;
  logic [31:0] cache_addr;
  logic [31:0] cache_din;
  logic        cache_is_ready;
  logic        cache_is_output_valid;
  logic        cache_is_hit;
  logic [31:0] cache_dout;
  logic        mem_stall;
  logic [31:0] mem_dout;
  logic        mem_dout_valid;
  logic        timeout_err;
  logic [1:0]  fsm_state;
`ifdef MEM_STAT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ex_mem_valid          (ex_mem_valid),
    .ex_mem_mem_read       (ex_mem_mem_read),
    .ex_mem_mem_write      (ex_mem_mem_write),
    .ex_mem_addr           (ex_mem_addr),
    .ex_mem_din            (ex_mem_din),
    .cache_is_input_valid  (cache_is_input_valid),
    .cache_mem_read        (cache_mem_read),
    .cache_mem_write       (cache_mem_write),
    .cache_addr            (cache_addr),
    .cache_din             (cache_din),
    .cache_is_ready        (cache_is_ready),
    .cache_is_output_valid (cache_is_output_valid),
    .cache_is_hit          (cache_is_hit),
    .cache_dout            (cache_dout),
    .mem_stall             (mem_stall),
    .mem_dout              (mem_dout),
    .mem_dout_valid        (mem_dout_valid),
    .timeout_err           (timeout_err),
`ifdef MEM_STAT_EN
    .hit_count             (hit_count),
    .miss_count            (miss_count),
`endif
    .fsm_state             (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_dout;
  logic [31:0] exp_addr;
  logic [31:0] exp_din;
  logic        exp_tmo;
  int          exp_hit;
  int          exp_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_mem_valid          = 1'b0;
    ex_mem_mem_read       = 1'b0;
    ex_mem_mem_write      = 1'b0;
    ex_mem_addr           = 32'd0;
    ex_mem_din            = 32'd0;
    cache_is_output_valid = 1'b0;
    cache_is_hit          = 1'b0;
    cache_dout            = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    check({tag, "_ival"}, {31'd0, cache_is_input_valid}, 32'd0);
    check({tag, "_crd"}, {31'd0, cache_mem_read}, 32'd0);
    check({tag, "_cwr"}, {31'd0, cache_mem_write}, 32'd0);
    check({tag, "_caddr"}, cache_addr, 32'd0);
    check({tag, "_cdin"}, cache_din, 32'd0);
    check({tag, "_dout"}, mem_dout, 32'd0);
    check({tag, "_dval"}, {31'd0, mem_dout_valid}, 32'd0);
    check({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
`ifdef MEM_STAT_EN
    check({tag, "_hits"}, hit_count, 32'd0);
    check({tag, "_misses"}, miss_count, 32'd0);
`endif
  endtask

  // One complete access. not_ready: cycles that cache_is_ready is held low.
  // resp_wait: WAIT cycles before the response (0 means the first WAIT cycle).
  // tmo: the cache never answers.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] din,
                        input int not_ready, input int resp_wait,
                        input logic [31:0] rdata, input logic tmo);
    logic is_rd;
    int   n_wait;
    is_rd            = rd;
    ex_mem_valid     = 1'b1;
    ex_mem_mem_read  = rd;
    ex_mem_mem_write = wr;
    ex_mem_addr      = addr;
    ex_mem_din       = din;
    cache_is_ready   = (not_ready == 0);
    #1;
    for (int i = 0; i < not_ready; i++) begin
      check({tag, "_nr_stall"}, {31'd0, mem_stall}, 32'd1);
      check({tag, "_nr_ival"}, {31'd0, cache_is_input_valid}, 32'd0);
      check({tag, "_nr_addr"}, cache_addr, exp_addr);
      cycle();
      if (i == not_ready - 1) cache_is_ready = 1'b1;
      #1;
    end
    check({tag, "_op_stall"}, {31'd0, mem_stall}, 32'd1);
    cycle();
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    ex_mem_mem_write = 1'b0;
    ex_mem_addr = 32'hFFFF_FFFF;
    ex_mem_din = 32'hFFFF_FFFF;
    #1;
    exp_addr = addr;
    exp_din  = din;
    // REQ cycle
    check({tag, "_req_ival"}, {31'd0, cache_is_input_valid}, 32'd1);
    check({tag, "_req_addr"}, cache_addr, exp_addr);
    check({tag, "_req_din"}, cache_din, exp_din);
    check({tag, "_req_rd"}, {31'd0, cache_mem_read}, {31'd0, is_rd});
    check({tag, "_req_wr"}, {31'd0, cache_mem_write}, {31'd0, wr & ~rd});
    check({tag, "_req_stall"}, {31'd0, mem_stall}, 32'd1);
    n_wait = tmo ? TMO : resp_wait + 1;
    for (int w = 0; w < n_wait; w++) begin
      cycle();
      cache_dout = rdata;
      if (!tmo && w == resp_wait) begin
        cache_is_output_valid = 1'b1;
        cache_is_hit          = 1'b1;
      end else if (w == 1) begin
        // A miss indication without a hit must not complete the access.
        cache_is_output_valid = 1'b1;
        cache_is_hit          = 1'b0;
      end else begin
        cache_is_output_valid = 1'b0;
        cache_is_hit          = 1'b0;
      end
      #1;
      check({tag, "_w_ival"}, {31'd0, cache_is_input_valid}, 32'd0);
      check({tag, "_w_stall"}, {31'd0, mem_stall}, 32'd1);
      check({tag, "_w_addr"}, cache_addr, exp_addr);
      check({tag, "_w_din"}, cache_din, exp_din);
      check({tag, "_w_tmo"}, {31'd0, timeout_err}, {31'd0, exp_tmo});
      check({tag, "_w_dval"}, {31'd0, mem_dout_valid}, 32'd0);
    end
    cycle();
    cache_is_output_valid = 1'b0;
    cache_is_hit = 1'b0;
    cache_dout = 32'h5A5A_5A5A;
    #1;
    // DONE cycle
    if (tmo) exp_tmo = 1'b1;
    else if (resp_wait == 0) exp_hit++;
    else exp_miss++;
    if (!tmo && is_rd) exp_q.push_back(rdata);
    check({tag, "_d_state"}, {30'd0, fsm_state}, 32'd3);
    check({tag, "_d_stall"}, {31'd0, mem_stall}, 32'd0);
    check({tag, "_d_tmo"}, {31'd0, timeout_err}, {31'd0, exp_tmo});
    if (exp_q.size() > 0) begin
      exp_dout = exp_q.pop_front();
      check({tag, "_d_dval"}, {31'd0, mem_dout_valid}, 32'd1);
    end else begin
      check({tag, "_d_dval"}, {31'd0, mem_dout_valid}, 32'd0);
    end
    check({tag, "_d_dout"}, mem_dout, exp_dout);
`ifdef MEM_STAT_EN
    check({tag, "_hits"}, hit_count, exp_hit);
    check({tag, "_misses"}, miss_count, exp_miss);
`endif
    cycle();
    #1;
    check({tag, "_i_state"}, {30'd0, fsm_state}, 32'd0);
    check({tag, "_i_dval"}, {31'd0, mem_dout_valid}, 32'd0);
    check({tag, "_i_stall"}, {31'd0, mem_stall}, 32'd0);
    check({tag, "_i_dout"}, mem_dout, exp_dout);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    cache_is_ready = 1'b0;
    clear_inputs();
    exp_dout = 32'd0; exp_addr = 32'd0; exp_din = 32'd0;
    exp_tmo = 1'b0; exp_hit = 0; exp_miss = 0;
    cycle();
    cycle();
    check_all_zero("rst");
    reset = 1'b0;
    cycle();
    #1;
    check("idle_stall", {31'd0, mem_stall}, 32'd0);
    check("idle_ival", {31'd0, cache_is_input_valid}, 32'd0);

    // Load with a hit in the first WAIT cycle
    run_op("ld40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    // Store, response after 5 WAIT cycles
    run_op("st80", 1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 0, 5, 32'hCAFE_F00D, 1'b0);
    // Cache not ready for 4 cycles
    run_op("nrdy", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4, 0, 32'h0BAD_F00D, 1'b0);
    // No response: watchdog
    run_op("tmo", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 0, 32'h1111_1111, 1'b1);
    // Normal load after timeout
    run_op("post", 1'b1, 1'b0, 32'h0000_0204, 32'h0, 0, 0, 32'h2222_2222, 1'b0);
    // Read and write together: served as a read
    run_op("rdwr", 1'b1, 1'b1, 32'h0000_0300, 32'h7777_7777, 0, 2, 32'h3333_3333, 1'b0);
    // Back-to-back loads
    run_op("b2b0", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'hA0A0_A0A0, 1'b0);
    run_op("b2b1", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 0, 0, 32'hB1B1_B1B1, 1'b0);

    // Reset asserted while a load sits in WAIT
    ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_addr = 32'h0000_0400;
    cycle();
    clear_inputs();
    cycle();
    #1;
    check("rw_state", {30'd0, fsm_state}, 32'd2);
    reset = 1'b1;
    #1;
    check_all_zero("rw_async");
    check("rw_stall", {31'd0, mem_stall}, 32'd0);
    cache_is_output_valid = 1'b1; cache_is_hit = 1'b1; cache_dout = 32'h4444_4444;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      #1;
      check("rw_dval", {31'd0, mem_dout_valid}, 32'd0);
      check("rw_idle", {30'd0, fsm_state}, 32'd0);
    end
    check_all_zero("rw_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
